fp_adder_scheduler: RTL and testbench
=====================================

Name: fp_adder_scheduler

Overview:
- Shares one floating-point adder datapath (its Control FSM plus shifters and rounder) between NREQ requesters.
- Arbitrates requests round-robin and launches the adder with a one-cycle Go pulse.
- Waits for the adder's Ready, then returns the sum to the winning requester with its ID tag.
- A timeout watchdog guarantees a response even if the adder never raises Ready.

Parameters:
- NREQ, 4, number of requesters (2..16)
- EXPBITS, 8, exponent width
- MANTISSABITS, 23, stored mantissa width; operand width W = 1+EXPBITS+MANTISSABITS
- TIMEOUT, 64, max cycles in WAIT before error response (≥4)

Ports:
- Clock  in  1  system clock, rising edge
- Reset  in  1  synchronous, active-low reset
- ReqValid  in  NREQ  per-requester request valid
- ReqA  in  NREQ×W  operand A per requester (packed array of float_t)
- ReqB  in  NREQ×W  operand B per requester
- ReqAccept  out  NREQ  one-hot; transfer occurs when ReqValid[i]&ReqAccept[i]
- Go  out  1  adder start pulse
- OpA  out  W  operand A to adder, stable from Go until Ready
- OpB  out  W  operand B to adder
- AdderReady  in  1  adder result valid pulse
- AdderSum  in  W  adder result
- RespValid  out  1  one-cycle response pulse
- RespId  out  $clog2(NREQ)  requester index of response
- RespSum  out  W  result (0 on error)
- RespError  out  1  qualifies RespValid: timeout occurred
- Busy  out  1  high whenever state≠IDLE

Behaviour:
- Reset (Reset==0 at posedge):
  - state=IDLE, RRPtr=0, timer=0.
  - Go, RespValid, RespError, Busy=0; OpA, OpB, RespSum, RespId=0.
  - Reset mid-operation abandons the transaction; no response is issued.
- FSM states IDLE→ISSUE→WAIT→RESP→IDLE. All outputs are registered except ReqAccept.
- IDLE:
  - Winner g = first i with ReqValid[i]=1, scanning RRPtr, RRPtr+1, … modulo NREQ.
  - ReqAccept[g]=1 combinationally, only in IDLE; all other bits 0.
  - On the edge: OpA=ReqA[g], OpB=ReqB[g], GrantId=g, →ISSUE.
  - No ReqValid: stay, ReqAccept=0.
- ISSUE: Go=1 for exactly this cycle; timer=0; →WAIT.
- WAIT:
  - AdderReady=1: RespSum=AdderSum, RespId=GrantId, RespError=0, →RESP.
  - Else timer++. At timer==TIMEOUT-1: RespSum=0, RespError=1, →RESP.
  - AdderReady and timeout in the same cycle: AdderReady wins, no error.
- RESP:
  - RespValid=1 for one cycle.
  - RRPtr=(GrantId+1) mod NREQ, updated on success and error alike.
  - →IDLE.
- AdderReady outside WAIT is ignored, including a late Ready after a timeout.
- OpA/OpB hold their value from ISSUE until the next IDLE capture.
- Latency: accept at cycle 0, Go at cycle 1, AdderReady at cycle k≥2, RespValid at cycle k+1, next accept possible at cycle k+2.
- Fairness: with all NREQ requesting continuously, grants rotate 0,1,…,NREQ-1,0,…; no requester waits more than NREQ-1 transactions.
- Requesters must hold ReqValid and operands until accepted. Dropping ReqValid before accept is legal and the request is simply not granted.
- Timer width: $clog2(TIMEOUT); no wrap is reachable.

Decomposition:
- Shared package fp_adder_pkg:
  - EXPBITS and MANTISSABITS defaults.
  - float_t packed struct {sign, exp[EXPBITS], mant[MANTISSABITS]}.
  - sched_state_t enum {IDLE, ISSUE, WAIT, RESP}.
- Sub-module rr_arbiter #(NREQ):
  - Combinational round-robin picker.
  - Inputs: request vector and pointer.
  - Outputs: one-hot grant, encoded index, any-valid flag.
- fp_adder_scheduler holds the FSM, timer, operand and response registers.

Test Plan:
- Reset held low 2 cycles while ReqValid=4'b1111 → ReqAccept=0, Go=0, RespValid=0, Busy=0 throughout; after release first accept is requester 0.
- Single request: ReqValid[2]=1, A=32'h3F800000, B=32'h40000000; model adder raises Ready 5 cycles after Go with 32'h40400000 → Go exactly one cycle after accept; RespValid 1 cycle after Ready with RespId=2, RespSum=32'h40400000, RespError=0.
- All four requesting continuously for 8 transactions → grant order 0,1,2,3,0,1,2,3; exactly one Go per transaction.
- Adder never raises Ready → RespValid with RespError=1, RespSum=0, RespId=winner, TIMEOUT cycles after WAIT entry; a late Ready afterwards produces no response; the next request proceeds normally.
- Ready asserted exactly on cycle TIMEOUT-1 of WAIT → normal response, RespError=0.
- Reset asserted during WAIT → no RespValid; after release, the pending requester is re-accepted starting from RRPtr=0.

Source files
------------

// File: rtl/fp_adder_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fp_adder_pkg : operand format, scheduler states and round-robin index helper
// Rev 1.0
// ---------------------------------------------------------------------------
package fp_adder_pkg;

  localparam int EXPBITS_DEF      = 8;
  localparam int MANTISSABITS_DEF = 23;

  typedef struct packed {
    logic                        sign;
    logic [EXPBITS_DEF-1:0]      exp;
    logic [MANTISSABITS_DEF-1:0] mant;
  } float_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } sched_state_t;

  // (ptr + off) mod n for ptr < n and off < n, without a divider
  function automatic int rr_index(input int ptr, input int off, input int n);
    int s;
    s = ptr + off;
    return (s >= n) ? s - n : s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_arbiter : combinational round-robin picker starting the scan at i_ptr
// Rev 1.0
// ---------------------------------------------------------------------------
module rr_arbiter
  import fp_adder_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int c_IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [c_IW-1:0] i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [c_IW-1:0] o_idx,
  output logic            o_any
);

  logic [c_IW-1:0] w_j;

  // Scan from the farthest offset down so the closest requester to i_ptr wins
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_j     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_j = c_IW'(rr_index(int'(i_ptr), k, NREQ));
      if (i_req[w_j]) begin
        o_grant      = '0;
        o_grant[w_j] = 1'b1;
        o_idx        = w_j;
        o_any        = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fp_adder_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fp_adder_scheduler : round-robin sharing of one FP adder with timeout watchdog
// Rev 1.0
// ---------------------------------------------------------------------------
module fp_adder_scheduler
  import fp_adder_pkg::*;
#(
  parameter  int NREQ         = 4,
  parameter  int EXPBITS      = EXPBITS_DEF,
  parameter  int MANTISSABITS = MANTISSABITS_DEF,
  parameter  int TIMEOUT      = 64,
  localparam int c_W          = 1 + EXPBITS + MANTISSABITS,
  localparam int c_IW         = $clog2(NREQ),
  localparam int c_TW         = $clog2(TIMEOUT)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NREQ-1:0]          i_req_valid,
  input  logic [NREQ-1:0][c_W-1:0] i_req_a,
  input  logic [NREQ-1:0][c_W-1:0] i_req_b,
  output logic [NREQ-1:0]          o_req_accept,
  output logic                     o_go,
  output logic [c_W-1:0]           o_op_a,
  output logic [c_W-1:0]           o_op_b,
  input  logic                     i_adder_ready,
  input  logic [c_W-1:0]           i_adder_sum,
  output logic                     o_resp_valid,
  output logic [c_IW-1:0]          o_resp_id,
  output logic [c_W-1:0]           o_resp_sum,
  output logic                     o_resp_error,
  output logic                     o_busy
);

  sched_state_t    r_state;
  sched_state_t    w_next;
  logic [NREQ-1:0] w_grant;
  logic [c_IW-1:0] w_grant_idx;
  logic            w_any;
  logic            w_timeout;
  logic [c_IW-1:0] r_rr_ptr;
  logic [c_IW-1:0] r_grant_id;
  logic [c_TW-1:0] r_timer;
  logic            r_go;
  logic            r_resp_valid;
  logic            r_resp_error;
  logic            r_busy;
  logic [c_W-1:0]  r_op_a;
  logic [c_W-1:0]  r_op_b;
  logic [c_W-1:0]  r_resp_sum;
  logic [c_IW-1:0] r_resp_id;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .i_req   (i_req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_grant_idx),
    .o_any   (w_any)
  );

  assign w_timeout = (r_timer == c_TW'(TIMEOUT - 1));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any) w_next = ISSUE;
      ISSUE:   w_next = WAIT;
      WAIT:    if (i_adder_ready || w_timeout) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // No transfer may be acknowledged while reset is holding the scheduler
  always_comb begin
    o_req_accept = '0;
    if (r_state == IDLE && i_rst_n) o_req_accept = w_grant;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rr_ptr     <= '0;
      r_grant_id   <= '0;
      r_timer      <= '0;
      r_go         <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_error <= 1'b0;
      r_busy       <= 1'b0;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_resp_sum   <= '0;
      r_resp_id    <= '0;
    end else begin
      r_go         <= (w_next == ISSUE);
      r_resp_valid <= (w_next == RESP);
      r_busy       <= (w_next != IDLE);
      case (r_state)
        IDLE: if (w_any) begin
          r_op_a     <= i_req_a[w_grant_idx];
          r_op_b     <= i_req_b[w_grant_idx];
          r_grant_id <= w_grant_idx;
        end
        ISSUE: r_timer <= '0;
        // A Ready coinciding with the last timer count still counts as success
        WAIT: begin
          if (i_adder_ready) begin
            r_resp_sum   <= i_adder_sum;
            r_resp_id    <= r_grant_id;
            r_resp_error <= 1'b0;
          end else if (w_timeout) begin
            r_resp_sum   <= '0;
            r_resp_id    <= r_grant_id;
            r_resp_error <= 1'b1;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        RESP: r_rr_ptr <= (r_grant_id == c_IW'(NREQ - 1)) ? '0 : r_grant_id + 1'b1;
        default: ;
      endcase
    end
  end

  assign o_go         = r_go;
  assign o_op_a       = r_op_a;
  assign o_op_b       = r_op_b;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_id    = r_resp_id;
  assign o_resp_sum   = r_resp_sum;
  assign o_resp_error = r_resp_error;
  assign o_busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_fp_adder_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fp_adder_scheduler : directed scoreboard bench with a behavioural adder
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_fp_adder_scheduler;
  import fp_adder_pkg::*;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 16;
  localparam int W       = 32;

  typedef struct packed {
    logic [1:0]   id;
    logic [W-1:0] sum;
    logic         err;
  } resp_t;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0][W-1:0] req_a;
  logic [NREQ-1:0][W-1:0] req_b;
  logic [NREQ-1:0]        req_accept;
  logic                   go;
  logic [W-1:0]           op_a;
  logic [W-1:0]           op_b;
  logic                   adder_ready;
  logic [W-1:0]           adder_sum;
  logic                   resp_valid;
  logic [1:0]             resp_id;
  logic [W-1:0]           resp_sum;
  logic                   resp_error;
  logic                   busy;

  int      checks = 0;
  int      failures = 0;
  int      cyc = 0;
  resp_t   exp_q[$];
  int      dut_log[$];
  int      m_ptr = 0;
  int      a_delay = 3;
  bit      a_fixed_en = 1'b0;
  logic [W-1:0] a_fixed = '0;
  int      a_cnt = 0;
  bit      a_late = 1'b0;
  bit      acc_now = 1'b0;
  int      acc_cnt = 0;
  int      go_cnt = 0;
  int      resp_cnt = 0;
  int      acc_cyc = 0;
  int      go_cyc = 0;
  int      rdy_cyc = 0;
  int      resp_cyc = 0;
  int      acc_idx = 0;

  fp_adder_scheduler #(
    .NREQ(NREQ), .EXPBITS(8), .MANTISSABITS(23), .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_req_valid   (req_valid),
    .i_req_a       (req_a),
    .i_req_b       (req_b),
    .o_req_accept  (req_accept),
    .o_go          (go),
    .o_op_a        (op_a),
    .o_op_b        (op_b),
    .i_adder_ready (adder_ready),
    .i_adder_sum   (adder_sum),
    .o_resp_valid  (resp_valid),
    .o_resp_id     (resp_id),
    .o_resp_sum    (resp_sum),
    .o_resp_error  (resp_error),
    .o_busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=still running exp=finished");
    $fatal(1, "watchdog");
  end

  function automatic int pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++)
      if (v[2'((p + k) % NREQ)]) return (p + k) % NREQ;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, want);
    end
  endtask

  // One clock: sample accept mid-cycle, then at the falling edge check Go,
  // drive the behavioural adder and score any response.
  task automatic step();
    int              g;
    logic [NREQ-1:0] exp_acc;
    resp_t           e;
    #1;
    acc_now = 1'b0;
    if (|req_accept) begin
      g = pick(req_valid, m_ptr);
      exp_acc = (g >= 0) ? (4'b0001 << g) : 4'b0000;
      checks++;
      assert (req_accept === exp_acc) else begin
        failures++;
        $error("FAIL accept obs=%b exp=%b", req_accept, exp_acc);
      end
      acc_now = 1'b1;
      acc_cnt++;
      acc_cyc = cyc;
      acc_idx = $clog2(req_accept);
      dut_log.push_back(acc_idx);
      if (g >= 0) begin
        e.id  = 2'(g);
        e.err = (a_delay == 0) || (a_delay > TIMEOUT);
        e.sum = e.err ? '0 : (a_fixed_en ? a_fixed : (req_a[2'(g)] ^ req_b[2'(g)]));
        exp_q.push_back(e);
        m_ptr = (g + 1) % NREQ;
      end
    end
    @(negedge clk);
    cyc++;
    checks++;
    assert (go === acc_now) else begin
      failures++;
      $error("FAIL go_after_accept obs=%b exp=%b", go, acc_now);
    end
    if (go) begin
      go_cnt++;
      go_cyc = cyc;
    end
    adder_ready = 1'b0;
    if (a_late) begin
      adder_ready = 1'b1;
      adder_sum   = 32'hDEAD_BEEF;
      a_late      = 1'b0;
    end else if (go) begin
      a_cnt = a_delay;
    end else if (a_cnt > 0) begin
      a_cnt--;
      if (a_cnt == 0) begin
        adder_ready = 1'b1;
        adder_sum   = a_fixed_en ? a_fixed : (op_a ^ op_b);
        rdy_cyc     = cyc;
      end
    end
    if (resp_valid) begin
      resp_cnt++;
      resp_cyc = cyc;
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL resp_unexpected obs=id%0d/%h/err%b exp=no response", resp_id, resp_sum, resp_error);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks += 3;
        assert (resp_id === e.id) else begin
          failures++;
          $error("FAIL resp_id obs=%0d exp=%0d", resp_id, e.id);
        end
        assert (resp_sum === e.sum) else begin
          failures++;
          $error("FAIL resp_sum obs=%h exp=%h", resp_sum, e.sum);
        end
        assert (resp_error === e.err) else begin
          failures++;
          $error("FAIL resp_error obs=%b exp=%b", resp_error, e.err);
        end
      end
    end
  endtask

  task automatic wait_acc(input string tag, input int bound);
    int n0;
    int i;
    n0 = acc_cnt;
    i  = 0;
    while (acc_cnt == n0 && i < bound) begin
      step();
      i++;
    end
    checks++;
    assert (acc_cnt != n0) else begin
      failures++;
      $error("FAIL %s accept_timeout obs=none exp=accept within %0d cycles", tag, bound);
    end
  endtask

  task automatic wait_resp(input string tag, input int bound);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < bound) begin
      step();
      i++;
    end
    checks++;
    assert (exp_q.size() == 0) else begin
      failures++;
      $error("FAIL %s resp_timeout obs=%0d pending exp=0 pending", tag, exp_q.size());
    end
  endtask

  initial begin
    float_t f_one;
    float_t f_two;
    float_t f_three;
    int     base_acc;
    int     base_go;
    int     base_resp;
    f_one   = '{sign: 1'b0, exp: 8'd127, mant: 23'd0};
    f_two   = '{sign: 1'b0, exp: 8'd128, mant: 23'd0};
    f_three = '{sign: 1'b0, exp: 8'd128, mant: 23'h40_0000};

    rst_n       = 1'b0;
    req_valid   = 4'b1111;
    adder_ready = 1'b0;
    adder_sum   = '0;
    req_a = {32'h4444_0004, 32'h3333_0003, 32'h2222_0002, 32'h1111_0001};
    req_b = {32'h0000_0F08, 32'h0000_0F04, 32'h0000_0F02, 32'h0000_0F01};

    // Reset held with every requester active
    repeat (2) begin
      step();
      chk("rst_accept", 32'(req_accept), 32'd0);
      chk("rst_go", 32'(go), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_op_a", op_a, 32'd0);
      chk("rst_resp_sum", resp_sum, 32'd0);
    end
    rst_n = 1'b1;
    m_ptr = 0;
    wait_acc("first", 10);
    chk("first_grant", 32'(acc_idx), 32'd0);
    req_valid = 4'b0000;
    wait_resp("first", 50);

    // Single request with the documented operands and a 5-cycle adder
    req_a[2]   = f_one;
    req_b[2]   = f_two;
    a_fixed_en = 1'b1;
    a_fixed    = f_three;
    a_delay    = 5;
    req_valid  = 4'b0100;
    wait_acc("single", 10);
    req_valid = 4'b0000;
    wait_resp("single", 50);
    chk("single_go_lat", 32'(go_cyc - acc_cyc), 32'd1);
    chk("single_resp_lat", 32'(resp_cyc - rdy_cyc), 32'd1);
    chk("single_total_lat", 32'(resp_cyc - acc_cyc), 32'd7);
    step();
    chk("single_idle_busy", 32'(busy), 32'd0);

    // All requesters continuously active: eight rotating grants
    a_fixed_en = 1'b0;
    a_delay    = 2;
    base_acc   = acc_cnt;
    base_go    = go_cnt;
    base_resp  = resp_cnt;
    dut_log.delete();
    req_valid  = 4'b1111;
    for (int n = 0; n < 400 && (acc_cnt - base_acc) < 8; n++) step();
    req_valid = 4'b0000;
    wait_resp("rotate", 50);
    chk("rotate_accepts", 32'(acc_cnt - base_acc), 32'd8);
    chk("rotate_gos", 32'(go_cnt - base_go), 32'd8);
    chk("rotate_resps", 32'(resp_cnt - base_resp), 32'd8);
    if (dut_log.size() == 8)
      for (int i = 1; i < 8; i++)
        chk("rotate_order", 32'(dut_log[i]), 32'((dut_log[i-1] + 1) % NREQ));

    // Adder never answers: error response, late Ready ignored, then recovery
    a_delay   = 0;
    req_valid = 4'b0001;
    wait_acc("timeout", 10);
    req_valid = 4'b0000;
    wait_resp("timeout", TIMEOUT + 20);
    chk("timeout_lat", 32'(resp_cyc - acc_cyc), 32'(TIMEOUT + 2));
    base_resp = resp_cnt;
    a_late    = 1'b1;
    repeat (4) step();
    chk("late_ready_ignored", 32'(resp_cnt - base_resp), 32'd0);
    a_delay   = 3;
    req_valid = 4'b0010;
    wait_acc("recover", 10);
    req_valid = 4'b0000;
    wait_resp("recover", 50);
    chk("recover_error", 32'(resp_error), 32'd0);

    // Ready on the last WAIT cycle wins; one cycle later is a timeout
    a_delay   = TIMEOUT;
    req_valid = 4'b0100;
    wait_acc("edge_ok", 10);
    req_valid = 4'b0000;
    wait_resp("edge_ok", TIMEOUT + 20);
    chk("edge_ok_lat", 32'(resp_cyc - acc_cyc), 32'(TIMEOUT + 2));
    a_delay   = TIMEOUT + 1;
    req_valid = 4'b1000;
    wait_acc("edge_late", 10);
    req_valid = 4'b0000;
    wait_resp("edge_late", TIMEOUT + 20);
    chk("edge_late_lat", 32'(resp_cyc - acc_cyc), 32'(TIMEOUT + 2));
    repeat (2) step();

    // Reset during WAIT abandons the transaction and the pointer restarts at 0
    a_delay   = 0;
    req_valid = 4'b0010;
    wait_acc("midrst", 10);
    req_valid = 4'b1010;
    repeat (3) step();
    chk("midrst_busy_before", 32'(busy), 32'd1);
    rst_n     = 1'b0;
    exp_q.delete();
    m_ptr     = 0;
    a_delay   = 3;
    base_resp = resp_cnt;
    repeat (2) step();
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_no_resp", 32'(resp_cnt - base_resp), 32'd0);
    rst_n = 1'b1;
    wait_acc("midrst_reaccept", 10);
    chk("midrst_reaccept_id", 32'(acc_idx), 32'd1);
    req_valid = 4'b0000;
    wait_resp("midrst", 50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
